display_arbiter: RTL



---
 rtl/display_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner selection for the shared 4-digit display, with a minimum dwell before preemption.
// Optional feature macro DISPLAY_ARB_GAP_EN inserts a blank gap of GAP_CYCLES edges between owners.
module display_arbiter #(
    parameter int         DWELL_CYCLES = 1000,
    parameter logic [3:0] BLANK_CODE   = 4'hF,
    parameter int         GAP_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [47:0] bcd_flat,
    output logic [2:0]  grant,
    output logic [1:0]  owner,
    output logic        active,
    output logic [15:0] bcd_out
);
    // state   | meaning
    // S_IDLE  | no owner, display blank
    // S_DWELL | owner granted, minimum dwell still running
    // S_OPEN  | dwell served, owner may be preempted
    // S_GAP   | blank gap between owners (DISPLAY_ARB_GAP_EN only)
`ifdef DISPLAY_ARB_GAP_EN
    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_OPEN, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_OPEN} state_t;
`endif

    localparam int            CW         = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_SAT  = CW'(DWELL_CYCLES);
    localparam logic [15:0]   BLANK_WORD = {4{BLANK_CODE}};

    if (DWELL_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
        $error("display_arbiter: DWELL_CYCLES and GAP_CYCLES must be >= 1");
    end

    state_t        r_state;
    logic [2:0]    r_grant;
    logic [1:0]    r_owner;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_bcd;

    state_t        w_state_nxt;
    logic          w_has_nxt;
    logic [1:0]    w_owner_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_change;
    logic [2:0]    w_owner_oh;
    logic          w_owner_req;
    logic          w_any_other;
    logic [1:0]    w_rr_win;
    logic [2:0]    w_grant_nxt;
    logic [15:0]   w_slice;
    logic [15:0]   w_bcd_nxt;

`ifdef DISPLAY_ARB_GAP_EN
    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [GW-1:0] r_gap_cnt;
    logic [1:0]    r_pend;
    logic          r_pend_vld;
    logic [GW-1:0] w_gap_cnt_nxt;
    logic [1:0]    w_pend_nxt;
    logic          w_pend_vld_nxt;
`endif

    // Search starts one past the last owner, so the last owner is always considered last.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        case (last)
            2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
            2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
            default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
        endcase
        if (r[a])      rr_pick = a;
        else if (r[b]) rr_pick = b;
        else           rr_pick = c;
    endfunction

    assign w_owner_oh  = 3'b001 << r_owner;
    assign w_owner_req = req[r_owner];
    assign w_any_other = |(req & ~w_owner_oh);
    assign w_rr_win    = rr_pick(req, r_owner);

    always_comb begin
        w_state_nxt = r_state;
        w_has_nxt   = |r_grant;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_change    = 1'b0;
`ifdef DISPLAY_ARB_GAP_EN
        w_gap_cnt_nxt  = r_gap_cnt;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
`endif
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_has_nxt   = 1'b1;
                    w_owner_nxt = w_rr_win;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DWELL;
                end
            end
            S_DWELL: begin
                if (!w_owner_req) begin
                    w_change = 1'b1;
                end else begin
                    if (r_cnt != DWELL_SAT) w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == DWELL_LAST) w_state_nxt = S_OPEN;
                end
            end
            S_OPEN: begin
                if (!w_owner_req || w_any_other) w_change = 1'b1;
            end
`ifdef DISPLAY_ARB_GAP_EN
            S_GAP: begin
                w_has_nxt = 1'b0;
                if (r_gap_cnt == '0) begin
                    w_pend_vld_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    if (r_pend_vld && req[r_pend]) begin
                        w_has_nxt   = 1'b1;
                        w_owner_nxt = r_pend;
                        w_state_nxt = S_DWELL;
                    end else if (|req) begin
                        w_has_nxt   = 1'b1;
                        w_owner_nxt = w_rr_win;
                        w_state_nxt = S_DWELL;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
`endif
            default: begin
                w_has_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_change) begin
`ifdef DISPLAY_ARB_GAP_EN
            w_has_nxt      = 1'b0;
            w_state_nxt    = S_GAP;
            w_gap_cnt_nxt  = GAP_LAST;
            w_pend_nxt     = w_rr_win;
            w_pend_vld_nxt = w_any_other;
`else
            if (w_any_other) begin
                w_has_nxt   = 1'b1;
                w_owner_nxt = w_rr_win;
                w_cnt_nxt   = '0;
                w_state_nxt = S_DWELL;
            end else begin
                w_has_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
`endif
        end
    end

    always_comb begin
        case (w_owner_nxt)
            2'd0:    w_slice = bcd_flat[15:0];
            2'd1:    w_slice = bcd_flat[31:16];
            default: w_slice = bcd_flat[47:32];
        endcase
        w_grant_nxt = w_has_nxt ? (3'b001 << w_owner_nxt) : 3'b000;
        w_bcd_nxt   = w_has_nxt ? w_slice : BLANK_WORD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= 3'b000;
            r_owner <= 2'd2;
            r_cnt   <= '0;
            r_bcd   <= BLANK_WORD;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bcd   <= w_bcd_nxt;
        end
    end

`ifdef DISPLAY_ARB_GAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt  <= '0;
            r_pend     <= 2'd0;
            r_pend_vld <= 1'b0;
        end else begin
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
        end
    end
`endif

    assign grant   = r_grant;
    assign owner   = r_owner;
    assign active  = |r_grant;
    assign bcd_out = r_bcd;
endmodule
